// File: rtl/decode_ctrl.sv
// RV32I decode stage: one-entry ID register, decodes at capture, outputs come straight from registers.
// Latency 1 cycle; ifReady drops when the held entry cannot drain (exReady low, load-use hazard, or flush).
module decode_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        ifValid,
    input  logic [31:0] ifInstr,
    input  logic [31:0] ifPc,
    output logic        ifReady,
    input  logic        exReady,
    input  logic        exIsLoad,
    input  logic [4:0]  exRd,
    input  logic        flush,
    output logic        idValid,
    output logic [31:0] idPc,
    output logic [2:0]  immCntrl,
    output logic [24:0] immSrc,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic        illegal
);

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;

    localparam logic [2:0] IMM_NONE  = 3'b000;
    localparam logic [2:0] IMM_SHAMT = 3'b001;
    localparam logic [2:0] IMM_I     = 3'b010;
    localparam logic [2:0] IMM_S     = 3'b011;
    localparam logic [2:0] IMM_B     = 3'b100;
    localparam logic [2:0] IMM_U     = 3'b101;
    localparam logic [2:0] IMM_J     = 3'b110;

    logic        r_valid;
    logic [31:0] r_pc;
    logic [2:0]  r_imm;
    logic [24:0] r_immSrc;
    logic [4:0]  r_rs1;
    logic [4:0]  r_rs2;
    logic [4:0]  r_rd;
    logic        r_rs1Used;
    logic        r_rs2Used;
    logic        r_illegal;

    logic [2:0]  w_imm;
    logic        w_rs1Used;
    logic        w_rs2Used;
    logic        w_illegal;
    logic        w_hazard;
    logic        w_idValid;
    logic        w_drain;
    logic        w_ifReady;

    always_comb begin
        w_imm     = IMM_NONE;
        w_rs1Used = 1'b0;
        w_rs2Used = 1'b0;
        w_illegal = 1'b0;
        case (ifInstr[6:0])
            OP_IMM: begin
                w_imm     = (ifInstr[13:12] == 2'b01) ? IMM_SHAMT : IMM_I;
                w_rs1Used = 1'b1;
            end
            LOAD, JALR: begin
                w_imm     = IMM_I;
                w_rs1Used = 1'b1;
            end
            STORE, BRANCH, OP: begin
                w_imm     = (ifInstr[6:0] == STORE)  ? IMM_S :
                            (ifInstr[6:0] == BRANCH) ? IMM_B : IMM_NONE;
                w_rs1Used = 1'b1;
                w_rs2Used = 1'b1;
            end
            LUI, AUIPC: w_imm = IMM_U;
            JAL:        w_imm = IMM_J;
            default:    w_illegal = 1'b1;
        endcase
    end

    // x0 is never a real producer, so a load targeting it cannot stall.
    assign w_hazard  = r_valid & exIsLoad & (exRd != 5'd0) &
                       ((r_rs1Used & (r_rs1 == exRd)) | (r_rs2Used & (r_rs2 == exRd)));
    assign w_idValid = r_valid & ~w_hazard & ~flush;
    assign w_drain   = w_idValid & exReady;
    assign w_ifReady = ~flush & (~r_valid | w_drain);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_pc      <= '0;
            r_imm     <= IMM_NONE;
            r_immSrc  <= '0;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_rd      <= '0;
            r_rs1Used <= 1'b0;
            r_rs2Used <= 1'b0;
            r_illegal <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (ifValid && w_ifReady) begin
            r_valid   <= 1'b1;
            r_pc      <= ifPc;
            r_imm     <= w_imm;
            r_immSrc  <= ifInstr[31:7];
            r_rs1     <= ifInstr[19:15];
            r_rs2     <= ifInstr[24:20];
            r_rd      <= ifInstr[11:7];
            r_rs1Used <= w_rs1Used;
            r_rs2Used <= w_rs2Used;
            r_illegal <= w_illegal;
        end else if (w_drain) begin
            r_valid <= 1'b0;
        end
    end

    assign ifReady  = w_ifReady;
    assign idValid  = w_idValid;
    assign idPc     = r_pc;
    assign immCntrl = r_imm;
    assign immSrc   = r_immSrc;
    assign rs1      = r_rs1;
    assign rs2      = r_rs2;
    assign rd       = r_rd;
    assign illegal  = r_illegal;

endmodule

// File: tb/tb_decode_ctrl.sv
// Directed bench for decode_ctrl: streaming table plus hand-written stall, flush and reset sequences.
module tb_decode_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifValid;
    logic [31:0] ifInstr;
    logic [31:0] ifPc;
    logic        ifReady;
    logic        exReady;
    logic        exIsLoad;
    logic [4:0]  exRd;
    logic        flush;
    logic        idValid;
    logic [31:0] idPc;
    logic [2:0]  immCntrl;
    logic [24:0] immSrc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] I_ADDI = 32'h00510093;
    localparam logic [31:0] I_SW   = 32'h00112423;
    localparam logic [31:0] I_SLLI = 32'h00419193;
    localparam logic [31:0] I_LUI  = 32'h123452B7;
    localparam logic [31:0] I_JAL  = 32'h000000EF;
    localparam logic [31:0] I_BEQ  = 32'h00000063;
    localparam logic [31:0] I_ILL  = 32'h0000007F;
    localparam logic [31:0] I_ADD  = 32'h00208233;

    always #5 clk = ~clk;

    decode_ctrl dut (
        .clk(clk), .rst(rst), .ifValid(ifValid), .ifInstr(ifInstr), .ifPc(ifPc),
        .ifReady(ifReady), .exReady(exReady), .exIsLoad(exIsLoad), .exRd(exRd),
        .flush(flush), .idValid(idValid), .idPc(idPc), .immCntrl(immCntrl),
        .immSrc(immSrc), .rs1(rs1), .rs2(rs2), .rd(rd), .illegal(illegal)
    );

    typedef struct {
        logic        vld;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        e_ifr;
        logic        e_idv;
        logic [2:0]  e_imm;
        logic        e_ill;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
    } vec_t;

    vec_t vecs[9];

    function automatic vec_t mk(logic v, logic [31:0] ins, logic [31:0] p, logic ifr, logic idv,
                                logic [2:0] imm, logic ill, logic [31:0] epc, logic [31:0] eins);
        vec_t t;
        t.vld = v; t.instr = ins; t.pc = p; t.e_ifr = ifr; t.e_idv = idv;
        t.e_imm = imm; t.e_ill = ill; t.e_pc = epc; t.e_instr = eins;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive inputs on the falling edge and let combinational outputs settle before sampling.
    task automatic cyc(input logic v, input logic [31:0] ins, input logic [31:0] p,
                       input logic er, input logic ld, input logic [4:0] erd,
                       input logic fl, input logic r);
        @(negedge clk);
        ifValid = v; ifInstr = ins; ifPc = p; exReady = er;
        exIsLoad = ld; exRd = erd; flush = fl; rst = r;
        #1;
    endtask

    initial begin
        logic [31:0] ei;
        rst = 1'b1; ifValid = 1'b0; ifInstr = '0; ifPc = '0; exReady = 1'b1;
        exIsLoad = 1'b0; exRd = '0; flush = 1'b0;

        vecs[0] = mk(1, I_ADDI, 32'h100, 1, 0, 3'b000, 0, 32'h000, 32'h0);
        vecs[1] = mk(1, I_SW,   32'h104, 1, 1, 3'b010, 0, 32'h100, I_ADDI);
        vecs[2] = mk(1, I_SLLI, 32'h108, 1, 1, 3'b011, 0, 32'h104, I_SW);
        vecs[3] = mk(1, I_LUI,  32'h10C, 1, 1, 3'b001, 0, 32'h108, I_SLLI);
        vecs[4] = mk(1, I_JAL,  32'h110, 1, 1, 3'b101, 0, 32'h10C, I_LUI);
        vecs[5] = mk(1, I_BEQ,  32'h114, 1, 1, 3'b110, 0, 32'h110, I_JAL);
        vecs[6] = mk(1, I_ILL,  32'h118, 1, 1, 3'b100, 0, 32'h114, I_BEQ);
        vecs[7] = mk(0, 32'h0,  32'h0,   1, 1, 3'b000, 1, 32'h118, I_ILL);
        vecs[8] = mk(0, 32'h0,  32'h0,   1, 0, 3'b000, 1, 32'h118, I_ILL);

        repeat (2) @(posedge clk);
        cyc(0, 0, 0, 1, 0, 0, 0, 0);
        chk("reset idValid", {31'b0, idValid}, 32'd0);
        chk("reset ifReady", {31'b0, ifReady}, 32'd1);
        chk("reset idPc", idPc, 32'd0);
        chk("reset immCntrl", {29'b0, immCntrl}, 32'd0);
        chk("reset immSrc", {7'b0, immSrc}, 32'd0);
        chk("reset regs", {17'b0, rs1, rs2, rd}, 32'd0);
        chk("reset illegal", {31'b0, illegal}, 32'd0);

        for (int i = 0; i < 9; i++) begin
            cyc(vecs[i].vld, vecs[i].instr, vecs[i].pc, 1, 0, 0, 0, 0);
            ei = vecs[i].e_instr;
            chk($sformatf("vec%0d ifReady", i), {31'b0, ifReady}, {31'b0, vecs[i].e_ifr});
            chk($sformatf("vec%0d idValid", i), {31'b0, idValid}, {31'b0, vecs[i].e_idv});
            chk($sformatf("vec%0d immCntrl", i), {29'b0, immCntrl}, {29'b0, vecs[i].e_imm});
            chk($sformatf("vec%0d illegal", i), {31'b0, illegal}, {31'b0, vecs[i].e_ill});
            chk($sformatf("vec%0d idPc", i), idPc, vecs[i].e_pc);
            chk($sformatf("vec%0d immSrc", i), {7'b0, immSrc}, {7'b0, ei[31:7]});
        end

        // Backpressure: ADD held, SW offered while exReady low for 3 cycles.
        cyc(1, I_ADD, 32'h200, 1, 0, 0, 0, 0);
        chk("bp capture ifReady", {31'b0, ifReady}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            cyc(1, I_SW, 32'h204, 0, 0, 0, 0, 0);
            chk($sformatf("bp%0d ifReady", k), {31'b0, ifReady}, 32'd0);
            chk($sformatf("bp%0d idValid", k), {31'b0, idValid}, 32'd1);
            chk($sformatf("bp%0d idPc", k), idPc, 32'h200);
            chk($sformatf("bp%0d regs", k), {17'b0, rs1, rs2, rd}, {17'b0, 5'd1, 5'd2, 5'd4});
        end
        cyc(1, I_SW, 32'h204, 1, 0, 0, 0, 0);
        chk("bp release ifReady", {31'b0, ifReady}, 32'd1);
        cyc(0, 0, 0, 1, 0, 0, 0, 0);
        chk("bp next idPc", idPc, 32'h204);
        chk("bp next immCntrl", {29'b0, immCntrl}, 32'd3);
        chk("bp next idValid", {31'b0, idValid}, 32'd1);

        // Load-use on rs1 (x1), then release.
        cyc(1, I_ADD, 32'h300, 1, 0, 0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            cyc(0, 0, 0, 1, 1, 5'd1, 0, 0);
            chk($sformatf("lu%0d idValid", k), {31'b0, idValid}, 32'd0);
            chk($sformatf("lu%0d ifReady", k), {31'b0, ifReady}, 32'd0);
        end
        cyc(0, 0, 0, 1, 0, 5'd1, 0, 0);
        chk("lu release idValid", {31'b0, idValid}, 32'd1);
        chk("lu release idPc", idPc, 32'h300);
        cyc(0, 0, 0, 1, 0, 0, 0, 0);
        chk("lu drained idValid", {31'b0, idValid}, 32'd0);

        // Load into x0 never stalls; load into rs2 (x2) does.
        cyc(1, I_ADD, 32'h304, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 5'd0, 0, 0);
        chk("x0 load idValid", {31'b0, idValid}, 32'd1);
        cyc(0, 0, 0, 0, 1, 5'd2, 0, 0);
        chk("rs2 load idValid", {31'b0, idValid}, 32'd0);
        cyc(0, 0, 0, 1, 1, 5'd5, 0, 0);
        chk("other rd idValid", {31'b0, idValid}, 32'd1);

        // Flush while holding ADDI and offering SW.
        cyc(1, I_ADDI, 32'h400, 1, 0, 0, 0, 0);
        cyc(1, I_SW, 32'h404, 1, 0, 0, 1, 0);
        chk("flush idValid", {31'b0, idValid}, 32'd0);
        chk("flush ifReady", {31'b0, ifReady}, 32'd0);
        cyc(0, 0, 0, 1, 0, 0, 0, 0);
        chk("post flush idValid", {31'b0, idValid}, 32'd0);
        chk("post flush ifReady", {31'b0, ifReady}, 32'd1);
        chk("post flush idPc", idPc, 32'h400);
        chk("post flush immCntrl", {29'b0, immCntrl}, 32'd2);

        // Reset in the middle of a load-use stall.
        cyc(1, I_ADD, 32'h500, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 5'd1, 0, 1);
        chk("stall before rst idValid", {31'b0, idValid}, 32'd0);
        cyc(0, 0, 0, 1, 1, 5'd1, 0, 0);
        chk("rst stall idValid", {31'b0, idValid}, 32'd0);
        chk("rst stall ifReady", {31'b0, ifReady}, 32'd1);
        chk("rst stall idPc", idPc, 32'd0);
        chk("rst stall immCntrl", {29'b0, immCntrl}, 32'd0);
        chk("rst stall regs", {17'b0, rs1, rs2, rd}, 32'd0);
        chk("rst stall immSrc", {7'b0, immSrc}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
